// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte using the
// request-to-send sequence. Lines are driven through open-drain pull-low enables.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StRts,
    StSend,
    StAck,
    StWaitIdle,
    StErr
  } state_e;

  localparam logic [19:0] InhibitLast = 20'(INHIBIT_CYCLES - 1);
  localparam logic [19:0] TimeoutLast = 20'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [8:0]  shift_q, shift_d;
  logic [19:0] cnt_q, cnt_d;
  logic [19:0] tmo_q, tmo_d;
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic        data_oe_q, data_oe_d;

  logic clk_s1_q, clk_s2_q, clk_prev_q;
  logic data_s1_q, data_s2_q;
  logic fall;
  logic tmo_expire;

  // Two-flop synchronizers plus a delayed copy of the clock for edge detection.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      data_s1_q  <= 1'b1;
      data_s2_q  <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      data_s1_q  <= ps2_data;
      data_s2_q  <= data_s1_q;
    end
  end

  assign fall       = clk_prev_q & ~clk_s2_q;
  assign tmo_expire = (tmo_q == TimeoutLast);

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      shift_q   <= 9'd0;
      cnt_q     <= 20'd0;
      tmo_q     <= 20'd0;
      bitcnt_q  <= 4'd0;
      data_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      bitcnt_q  <= bitcnt_d;
      data_oe_q <= data_oe_d;
    end
  end

  // Next-state and datapath update; timeout takes priority over a clock fall.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    bitcnt_d  = bitcnt_q;
    data_oe_d = data_oe_q;
    unique case (state_q)
      StIdle: begin
        data_oe_d = 1'b0;
        if (tx_valid) begin
          state_d = StInhibit;
          cnt_d   = 20'd0;
          shift_d = {~^tx_data, tx_data};
        end
      end
      StInhibit: begin
        if (cnt_q == InhibitLast) begin
          state_d = StRts;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      StRts: begin
        state_d   = StSend;
        bitcnt_d  = 4'd0;
        tmo_d     = 20'd0;
        data_oe_d = 1'b1; // start bit held until the first fall
      end
      StSend: begin
        if (tmo_expire) begin
          state_d = StErr;
        end else begin
          tmo_d = tmo_q + 20'd1;
          if (fall) begin
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd9) begin
              data_oe_d = 1'b0; // stop bit
              state_d   = StAck;
            end else begin
              data_oe_d = ~shift_q[bitcnt_q];
            end
          end
        end
      end
      StAck: begin
        if (tmo_expire) begin
          state_d = StErr;
        end else begin
          tmo_d = tmo_q + 20'd1;
          if (fall) begin
            state_d = data_s2_q ? StErr : StWaitIdle;
          end
        end
      end
      StWaitIdle: begin
        if (tmo_expire) begin
          state_d = StErr;
        end else begin
          tmo_d = tmo_q + 20'd1;
          if (clk_s2_q && data_s2_q) begin
            state_d = StIdle;
          end
        end
      end
      StErr: begin
        data_oe_d = 1'b0;
        state_d   = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    tx_ready    = 1'b0;
    tx_busy     = 1'b1;
    tx_done     = 1'b0;
    tx_error    = 1'b0;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_ready = 1'b1;
        tx_busy  = 1'b0;
      end
      StInhibit: begin
        ps2_clk_oe = 1'b1;
      end
      StRts: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = 1'b1;
      end
      StSend: begin
        ps2_data_oe = data_oe_q;
      end
      StAck: begin
        ps2_data_oe = 1'b0;
      end
      StWaitIdle: begin
        tx_done = clk_s2_q & data_s2_q & ~tmo_expire;
      end
      StErr: begin
        tx_error = 1'b1;
      end
      default: begin
        tx_busy = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on the open-drain lines.
module tb_ps2_host_tx;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx_busy, tx_done, tx_error;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk, ps2_data;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  assign ps2_clk  = dev_clk & ~ps2_clk_oe;
  assign ps2_data = dev_data & ~ps2_data_oe;

  always #5 clock = ~clock;

  ps2_host_tx #(
    .INHIBIT_CYCLES(20),
    .TIMEOUT_CYCLES(3000)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always @(negedge clock) begin
    if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
    if (tx_error === 1'b1) err_cnt <= err_cnt + 1;
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clock);
    while (tx_ready !== 1'b1 && n < 5000) begin
      @(negedge clock);
      n++;
    end
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
    vectors++;
    if (tx_ready !== 1'b0 || tx_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL accept: ready=%b busy=%b, want ready=0 busy=1", tx_ready, tx_busy);
    end
  endtask

  // Device: wait for clock release, then 11 clocks; start read before clock 1.
  task automatic device_frame(input bit ack, output logic [10:0] bits);
    int n;
    n = 0;
    bits = '1;
    while (ps2_clk_oe !== 1'b0 && n < 500) begin
      @(negedge clock);
      n++;
    end
    vectors++;
    if (n >= 500) begin
      miscompares++;
      $display("FAIL dev_release: clk_oe=%b after %0d cycles, want 0", ps2_clk_oe, n);
    end
    repeat (10) @(negedge clock);
    bits[0] = ps2_data;
    for (int i = 1; i <= 10; i++) begin
      dev_clk = 1'b0;
      repeat (25) @(negedge clock);
      dev_clk = 1'b1;
      bits[i] = ps2_data;
      if (i == 10) begin
        repeat (12) @(negedge clock);
        dev_data = ack ? 1'b0 : 1'b1;
        repeat (13) @(negedge clock);
      end else begin
        repeat (25) @(negedge clock);
      end
    end
    dev_clk = 1'b0;
    repeat (25) @(negedge clock);
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (25) @(negedge clock);
  endtask

  task automatic measure_rts();
    int n;
    n = 0;
    while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0 && n < 100) begin
      n++;
      @(negedge clock);
    end
    vectors++;
    if (n != 20) begin
      miscompares++;
      $display("FAIL inhibit_len: got %0d cycles, want 20", n);
    end
    vectors++;
    if (ps2_clk_oe !== 1'b1 || ps2_data_oe !== 1'b1) begin
      miscompares++;
      $display("FAIL rts: clk_oe=%b data_oe=%b, want 1 1", ps2_clk_oe, ps2_data_oe);
    end
    @(negedge clock);
    vectors++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b1) begin
      miscompares++;
      $display("FAIL send_entry: clk_oe=%b data_oe=%b, want 0 1", ps2_clk_oe, ps2_data_oe);
    end
  endtask

  task automatic run_frame(input logic [7:0] b, input logic par, input bit ack,
                           input bit inject);
    logic [10:0] bits;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(b);
    fork
      measure_rts();
      device_frame(ack, bits);
      if (inject) begin
        repeat (30) @(negedge clock);
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        repeat (100) @(negedge clock);
        tx_valid = 1'b0;
      end
    join
    repeat (5) @(negedge clock);
    vectors++;
    if (bits[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL start_bit %h: got %b want 0", b, bits[0]);
    end
    vectors++;
    if (bits[8:1] !== b) begin
      miscompares++;
      $display("FAIL data_bits: got %h want %h", bits[8:1], b);
    end
    vectors++;
    if (bits[9] !== par) begin
      miscompares++;
      $display("FAIL parity %h: got %b want %b", b, bits[9], par);
    end
    vectors++;
    if (bits[10] !== 1'b1) begin
      miscompares++;
      $display("FAIL stop_bit %h: got %b want 1", b, bits[10]);
    end
    vectors++;
    if ((done_cnt - d0) != (ack ? 1 : 0) || (err_cnt - e0) != (ack ? 0 : 1)) begin
      miscompares++;
      $display("FAIL outcome %h: done=%0d err=%0d, want done=%0d err=%0d", b,
               done_cnt - d0, err_cnt - e0, ack ? 1 : 0, ack ? 0 : 1);
    end
    vectors++;
    if (tx_ready !== 1'b1 || tx_busy !== 1'b0 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0)
    begin
      miscompares++;
      $display("FAIL idle_after %h: ready=%b busy=%b oe=%b%b, want 1 0 00", b, tx_ready,
               tx_busy, ps2_clk_oe, ps2_data_oe);
    end
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clock);
    vectors++;
    if (tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0 || tx_error !== 1'b0 ||
        ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: ready=%b busy=%b done=%b err=%b oe=%b%b", tx_ready,
               tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe);
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_send_ed();
    run_frame(8'hED, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_send_zero();
    run_frame(8'h00, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_nack();
    run_frame(8'h5A, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    int n, k, d0;
    d0 = done_cnt;
    send_byte(8'h12);
    n = 0;
    while (ps2_clk_oe !== 1'b0 && n < 500) begin
      @(negedge clock);
      n++;
    end
    k = 0;
    while (tx_error !== 1'b1 && k < 4000) begin
      @(negedge clock);
      k++;
    end
    vectors++;
    if (k != 3000) begin
      miscompares++;
      $display("FAIL timeout_latency: got %0d cycles, want 3000", k);
    end
    vectors++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_lines: oe=%b%b, want 00", ps2_clk_oe, ps2_data_oe);
    end
    @(negedge clock);
    vectors++;
    if (tx_ready !== 1'b1 || (done_cnt - d0) != 0) begin
      miscompares++;
      $display("FAIL timeout_idle: ready=%b done=%0d, want 1 0", tx_ready, done_cnt - d0);
    end
  endtask

  task automatic test_ignore_valid();
    run_frame(8'hF4, 1'b0, 1'b1, 1'b1);
    repeat (40) @(negedge clock);
    vectors++;
    if (tx_busy !== 1'b0 || ps2_clk_oe !== 1'b0) begin
      miscompares++;
      $display("FAIL ignored_req: busy=%b clk_oe=%b, want 0 0", tx_busy, ps2_clk_oe);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n, d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(8'h3C);
    n = 0;
    while (ps2_clk_oe !== 1'b0 && n < 500) begin
      @(negedge clock);
      n++;
    end
    repeat (10) @(negedge clock);
    for (int i = 1; i <= 4; i++) begin
      dev_clk = 1'b0;
      repeat (25) @(negedge clock);
      dev_clk = 1'b1;
      repeat (25) @(negedge clock);
    end
    dev_clk = 1'b0;
    repeat (8) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    vectors++;
    if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_busy !== 1'b0 || tx_ready !== 1'b1)
    begin
      miscompares++;
      $display("FAIL mid_reset: oe=%b%b busy=%b ready=%b, want 00 0 1", ps2_clk_oe,
               ps2_data_oe, tx_busy, tx_ready);
    end
    repeat (17) @(negedge clock);
    dev_clk = 1'b1;
    repeat (40) @(negedge clock);
    vectors++;
    if ((done_cnt - d0) != 0 || (err_cnt - e0) != 0 || tx_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_quiet: done=%0d err=%0d busy=%b, want 0 0 0", done_cnt - d0,
               err_cnt - e0, tx_busy);
    end
    run_frame(8'hAA, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_send_ed();
    test_send_zero();
    test_nack();
    test_timeout();
    test_ignore_valid();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
